div_ratio_ctrl: RTL and testbench

DIV_RATIO_CTRL -- requirements
Module: div_ratio_ctrl

---
 rtl/div_ratio_ctrl.sv | 105 ++++++++++
 tb/tb_div_ratio_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_ratio_ctrl.sv
// Purpose : glitch-free divide-ratio update; gates the divider on a falling edge, loads, settles.
// Latency : o_div_ratio updates 2 edges after a WAIT_LOW exit; enable low for 2+SETTLE_CYCLES cycles.
// Backpressure: o_cfg_ready is high only in IDLE; requests outside IDLE are dropped, not queued.
//
// Ports:
//   i_ref_clk, i_rst_n       : clock (rising edge) and async active-low reset
//   i_run                    : request for the divided clock
//   i_cfg_valid/i_cfg_ratio  : new-ratio request, taken when o_cfg_ready is high
//   o_cfg_ready              : high in IDLE
//   i_div_clk                : divider output clock fed back for falling-edge detection
//   o_div_ratio/o_clk_enable : registered controls to the divider
//   o_cfg_err/o_timeout      : one-cycle pulses (rejected ratio / forced reload)
module div_ratio_ctrl #(
  parameter logic [3:0]  DEFAULT_RATIO = 4'd2,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned EDGE_TIMEOUT  = 32
) (
  input  logic       i_ref_clk,
  input  logic       i_rst_n,
  input  logic       i_run,
  input  logic       i_cfg_valid,
  input  logic [3:0] i_cfg_ratio,
  output logic       o_cfg_ready,
  input  logic       i_div_clk,
  output logic [3:0] o_div_ratio,
  output logic       o_clk_enable,
  output logic       o_cfg_err,
  output logic       o_timeout
);

  typedef enum logic [2:0] {IDLE, WAIT_LOW, GATE, LOAD, SETTLE} state_t;

  localparam logic [5:0] TMO_LAST    = 6'(EDGE_TIMEOUT - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic       div_clk_q;
  logic [5:0] wait_cnt;
  logic [3:0] settle_cnt;
  logic [3:0] pending;

  logic accept, ratio_bad, ratio_same, fall, tmo_hit, tmo_fire;

  assign o_cfg_ready = (state == IDLE);
  assign accept      = i_cfg_valid & o_cfg_ready;
  assign ratio_bad   = (i_cfg_ratio < 4'd2);
  assign ratio_same  = (i_cfg_ratio == o_div_ratio);
  assign fall        = div_clk_q & ~i_div_clk;
  // wait_cnt holds the number of WAIT_LOW cycles already completed, so this
  // fires on the EDGE_TIMEOUT-th cycle spent there.
  assign tmo_hit     = (wait_cnt == TMO_LAST);

  always_comb begin
    state_nxt = state;
    tmo_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (accept && !ratio_bad && !ratio_same) state_nxt = WAIT_LOW;
      end
      WAIT_LOW: begin
        // A real falling edge wins over a coincident timeout; with the divider
        // already disabled there is no edge to wait for.
        if (fall || !o_clk_enable) begin
          state_nxt = GATE;
        end else if (tmo_hit) begin
          state_nxt = GATE;
          tmo_fire  = 1'b1;
        end
      end
      GATE:    state_nxt = LOAD;
      LOAD:    state_nxt = SETTLE;
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      div_clk_q    <= 1'b0;
      wait_cnt     <= '0;
      settle_cnt   <= '0;
      pending      <= '0;
      o_div_ratio  <= DEFAULT_RATIO;
      o_clk_enable <= 1'b0;
      o_cfg_err    <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      state        <= state_nxt;
      div_clk_q    <= i_div_clk;
      o_cfg_err    <= accept & ratio_bad;
      o_timeout    <= tmo_fire;
      o_clk_enable <= i_run & ((state_nxt == IDLE) || (state_nxt == WAIT_LOW));
      wait_cnt     <= ((state == WAIT_LOW) && (state_nxt == WAIT_LOW)) ? wait_cnt + 6'd1 : '0;
      settle_cnt   <= ((state == SETTLE) && (state_nxt == SETTLE)) ? settle_cnt + 4'd1 : '0;
      if ((state == IDLE) && (state_nxt == WAIT_LOW)) pending <= i_cfg_ratio;
      // Enable is already low during GATE, so the divider never sees a ratio
      // change while it is running.
      if (state == GATE) o_div_ratio <= pending;
    end
  end

endmodule

// File: tb/tb_div_ratio_ctrl.sv
module tb_div_ratio_ctrl;

  logic       ref_clk = 1'b0;
  logic       rst_n, run, cfg_valid, div_clk;
  logic [3:0] cfg_ratio;
  logic       cfg_ready, clk_enable, cfg_err, timeout;
  logic [3:0] div_ratio;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc;

  typedef struct {
    string      name;
    int         cyc;
    logic [3:0] ratio;
    logic       en, err, tmo, rdy;
  } exp_t;

  exp_t exp_q[$];

  div_ratio_ctrl dut (
    .i_ref_clk    (ref_clk),
    .i_rst_n      (rst_n),
    .i_run        (run),
    .i_cfg_valid  (cfg_valid),
    .i_cfg_ratio  (cfg_ratio),
    .o_cfg_ready  (cfg_ready),
    .i_div_clk    (div_clk),
    .o_div_ratio  (div_ratio),
    .o_clk_enable (clk_enable),
    .o_cfg_err    (cfg_err),
    .o_timeout    (timeout)
  );

  always #5 ref_clk = ~ref_clk;

  // Edge counter since the last reset release; read only at falling edges.
  always @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1, "watchdog expired");
  end

  // Monitor: any output activity (error/timeout pulse, ratio or enable change)
  // consumes the next expected event and compares the full output snapshot.
  logic [3:0] prev_ratio = 4'd0;
  logic       prev_en    = 1'b0;
  exp_t       e;

  always @(negedge ref_clk) begin
    if (rst_n === 1'b1) begin
      if (cfg_err || timeout || (div_ratio != prev_ratio) || (clk_enable != prev_en)) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: cyc=%0d ratio=%0d en=%b err=%b tmo=%b rdy=%b, none expected",
                   cyc, div_ratio, clk_enable, cfg_err, timeout, cfg_ready);
        end else begin
          e = exp_q.pop_front();
          if (cyc != e.cyc || div_ratio !== e.ratio || clk_enable !== e.en ||
              cfg_err !== e.err || timeout !== e.tmo || cfg_ready !== e.rdy) begin
            n_fail++;
            $display("FAIL %s: got cyc=%0d ratio=%0d en=%b err=%b tmo=%b rdy=%b, want cyc=%0d ratio=%0d en=%b err=%b tmo=%b rdy=%b",
                     e.name, cyc, div_ratio, clk_enable, cfg_err, timeout, cfg_ready,
                     e.cyc, e.ratio, e.en, e.err, e.tmo, e.rdy);
          end
        end
      end
    end
    prev_ratio = div_ratio;
    prev_en    = clk_enable;
  end

  task automatic push_exp(input string name, input int c, input logic [3:0] r,
                          input logic en, input logic err, input logic tmo, input logic rdy);
    exp_t x;
    x.name = name; x.cyc = c; x.ratio = r; x.en = en; x.err = err; x.tmo = tmo; x.rdy = rdy;
    exp_q.push_back(x);
  endtask

  // Gate at edge g, new ratio visible after g+1, back in IDLE with enable after g+4.
  task automatic push_reload(input string tag, input int g, input logic [3:0] old_r,
                             input logic [3:0] new_r, input logic tmo);
    push_exp({tag, "_gate"}, g,     old_r, 1'b0, 1'b0, tmo,  1'b0);
    push_exp({tag, "_load"}, g + 1, new_r, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp({tag, "_idle"}, g + 4, new_r, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ratio"}, 32'(div_ratio),  32'd2);
    chk({tag, "_en"},    32'(clk_enable), 32'd0);
    chk({tag, "_rdy"},   32'(cfg_ready),  32'd1);
    chk({tag, "_err"},   32'(cfg_err),    32'd0);
    chk({tag, "_tmo"},   32'(timeout),    32'd0);
  endtask

  task automatic to_cyc(input int t);
    while (cyc < t) @(negedge ref_clk);
  endtask

  initial begin
    int c, g;
    rst_n = 1'b0; run = 1'b1; cfg_valid = 1'b0; cfg_ratio = 4'd0; div_clk = 1'b1;
    repeat (2) @(negedge ref_clk);
    chk_reset_vals("reset");

    // Reset release with run high: enable one edge later.
    rst_n = 1'b1;
    push_exp("rst_release_en", 1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    to_cyc(3);

    // Ratios 1 then 0 are rejected back to back.
    c = cyc;
    cfg_valid = 1'b1; cfg_ratio = 4'd1;
    push_exp("err_ratio1", c + 1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge ref_clk);
    cfg_ratio = 4'd0;
    push_exp("err_ratio0", c + 2, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge ref_clk);
    cfg_valid = 1'b0;
    to_cyc(c + 6);

    // Same ratio as current: no activity at all.
    cfg_valid = 1'b1; cfg_ratio = 4'd2;
    @(negedge ref_clk);
    cfg_valid = 1'b0;
    repeat (3) @(negedge ref_clk);
    chk("same_ratio_ready", 32'(cfg_ready), 32'd1);
    chk("same_ratio_ratio", 32'(div_ratio), 32'd2);

    // Ratio 6, falling edge detected 5 cycles after acceptance; requests in
    // WAIT_LOW (a bad one and a good one) are ignored.
    c = cyc; g = c + 6;
    cfg_valid = 1'b1; cfg_ratio = 4'd6;
    push_reload("b", g, 4'd2, 4'd6, 1'b0);
    @(negedge ref_clk);
    cfg_ratio = 4'd0;
    @(negedge ref_clk);
    cfg_ratio = 4'd3;
    @(negedge ref_clk);
    cfg_valid = 1'b0;
    chk("busy_not_ready", 32'(cfg_ready), 32'd0);
    to_cyc(c + 5);
    div_clk = 1'b0;
    to_cyc(g + 6);
    div_clk = 1'b1;

    // Divider clock stuck high: forced reload after 32 WAIT_LOW cycles.
    c = cyc; g = c + 33;
    cfg_valid = 1'b1; cfg_ratio = 4'd5;
    push_reload("tmo", g, 4'd6, 4'd5, 1'b1);
    @(negedge ref_clk);
    cfg_valid = 1'b0;
    to_cyc(g + 6);

    // Falling edge on the very timeout cycle: edge path, no timeout pulse.
    c = cyc; g = c + 33;
    cfg_valid = 1'b1; cfg_ratio = 4'd7;
    push_reload("coinc", g, 4'd5, 4'd7, 1'b0);
    @(negedge ref_clk);
    cfg_valid = 1'b0;
    to_cyc(g - 1);
    div_clk = 1'b0;
    to_cyc(g + 6);
    div_clk = 1'b1;

    // run low: enable follows one cycle later, reload needs no edge.
    c = cyc;
    run = 1'b0;
    push_exp("run_off", c + 1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge ref_clk);
    c = cyc;
    cfg_valid = 1'b1; cfg_ratio = 4'd4;
    push_exp("norun_load", c + 3, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge ref_clk);
    cfg_valid = 1'b0;
    to_cyc(c + 5);
    chk("norun_ratio_4cyc", 32'(div_ratio), 32'd4);
    to_cyc(c + 8);
    run = 1'b1;
    push_exp("run_on", c + 9, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    to_cyc(c + 11);

    // Load 9, then reset pulse during SETTLE.
    c = cyc; g = c + 2;
    cfg_valid = 1'b1; cfg_ratio = 4'd9;
    push_exp("r9_gate", g,     4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp("r9_load", g + 1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge ref_clk);
    cfg_valid = 1'b0;
    div_clk = 1'b0;
    to_cyc(g + 3);
    chk("settle_not_ready", 32'(cfg_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    div_clk = 1'b1;
    @(negedge ref_clk);
    @(negedge ref_clk);
    rst_n = 1'b1;
    push_exp("rerelease_en", 1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    to_cyc(6);

    chk("events_left", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
